mips_avalon_master: RTL and testbench

- Parametrised successor to the single-wrapper bus glue: an Avalon-MM master that arbitrates between an instruction-fetch request port and a data request port of the Harvard core.
- Adds sub-word load lane extraction with sign or zero extension, store lane/byteenable steering, misalignment faulting, and an optional waitrequest timeout.
- Sits between mips_cpu_harvard request/handshake ports and the external Avalon bus; one transaction outstanding at a time.

---
 rtl/mips_avalon_master.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_mips_avalon_master.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_avalon_master.sv
// Avalon-MM master shared by the instruction-fetch and data ports of the
// Harvard core. Only one transaction is in flight at a time. Sub-word loads
// are extracted and extended, and stores are steered onto byte lanes.
// Misaligned or reserved-size accesses fault without starting a bus cycle.
module mips_avalon_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter bit DATA_PRIORITY  = 1'b1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    // instruction-fetch port
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic [31:0]           i_rdata,
    output logic                  i_fault,
    // data port
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [1:0]            d_size,
    input  logic                  d_signed,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_ack,
    output logic [31:0]           d_rdata,
    output logic                  d_fault,
    // Avalon-MM master
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read,
    output logic                  write,
    input  logic                  waitrequest,
    output logic [31:0]           writedata,
    output logic [3:0]            byteenable,
    input  logic [31:0]           readdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int         CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t state_q, state_d;

    // context of the transaction in flight
    logic                  sel_data_q, sel_data_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  sext_q, sext_d;
    logic [1:0]            lane_q, lane_d;
    logic                  last_data_q, last_data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // registered outputs
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic [31:0]           writedata_q, writedata_d;
    logic [3:0]            byteenable_q, byteenable_d;
    logic                  i_ack_q, i_ack_d;
    logic [31:0]           i_rdata_q, i_rdata_d;
    logic                  i_fault_q, i_fault_d;
    logic                  d_ack_q, d_ack_d;
    logic [31:0]           d_rdata_q, d_rdata_d;
    logic                  d_fault_q, d_fault_d;

    // request decode
    logic                  any_req;
    logic                  pick_data;
    logic                  req_fault;
    logic [3:0]            be_req;
    logic [31:0]           wdata_req;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           load_ext;
    logic                  timed_out;

    // Arbitration: on a tie the fetch port wins straight after a data access, otherwise DATA_PRIORITY decides
    always_comb begin
        any_req = i_req | d_req;
        if (i_req && d_req) begin
            pick_data = last_data_q ? 1'b0 : DATA_PRIORITY;
        end else begin
            pick_data = d_req;
        end
    end

    // Alignment and size check for the selected requester
    always_comb begin
        req_fault = 1'b0;
        if (pick_data) begin
            case (d_size)
                SZ_BYTE: req_fault = 1'b0;
                SZ_HALF: req_fault = d_addr[0];
                SZ_WORD: req_fault = (d_addr[1:0] != 2'b00);
                default: req_fault = 1'b1;
            endcase
        end else begin
            req_fault = (i_addr[1:0] != 2'b00);
        end
    end

    // Little-endian lane steering; loads and fetches enable all four lanes
    always_comb begin
        be_req    = 4'b1111;
        wdata_req = d_wdata;
        if (pick_data && d_we) begin
            case (d_size)
                SZ_BYTE: begin
                    be_req    = 4'b0001 << d_addr[1:0];
                    wdata_req = {4{d_wdata[7:0]}};
                end
                SZ_HALF: begin
                    be_req    = d_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_req = {2{d_wdata[15:0]}};
                end
                default: begin
                    be_req    = 4'b1111;
                    wdata_req = d_wdata;
                end
            endcase
        end
    end

    // Load lane extraction with sign or zero extension
    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = readdata[7:0];
            2'd1:    ld_byte = readdata[15:8];
            2'd2:    ld_byte = readdata[23:16];
            default: ld_byte = readdata[31:24];
        endcase
        ld_half = lane_q[1] ? readdata[31:16] : readdata[15:0];
        case (size_q)
            SZ_BYTE: load_ext = {{24{sext_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: load_ext = {{16{sext_q & ld_half[15]}}, ld_half};
            default: load_ext = readdata;
        endcase
    end

    // A stalled cycle that would be the TIMEOUT_CYCLES-th one aborts the transfer
    assign timed_out = (TIMEOUT_CYCLES != 0) && waitrequest &&
                       (int'(cnt_q) == TIMEOUT_CYCLES - 1);

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block and wins over any transition
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = req_fault ? RESP : BUS;
            BUS:     if (!waitrequest || timed_out) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output logic: next values of the Avalon signals, the responses and the transfer context
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch)
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        sel_data_d   = sel_data_q;
        we_d         = we_q;
        size_d       = size_q;
        sext_d       = sext_q;
        lane_d       = lane_q;
        last_data_d  = last_data_q;
        cnt_d        = cnt_q;
        i_ack_d      = 1'b0;
        i_rdata_d    = '0;
        i_fault_d    = 1'b0;
        d_ack_d      = 1'b0;
        d_rdata_d    = '0;
        d_fault_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel_data_d  = pick_data;
                    last_data_d = pick_data;
                    we_d        = pick_data & d_we;
                    size_d      = pick_data ? d_size : SZ_WORD;
                    sext_d      = pick_data & d_signed;
                    lane_d      = pick_data ? d_addr[1:0] : 2'b00;
                    if (req_fault) begin
                        i_ack_d   = ~pick_data;
                        i_fault_d = ~pick_data;
                        d_ack_d   = pick_data;
                        d_fault_d = pick_data;
                    end else begin
                        address_d    = pick_data ? {d_addr[ADDR_WIDTH-1:2], 2'b00}
                                                 : {i_addr[ADDR_WIDTH-1:2], 2'b00};
                        read_d       = ~we_d;
                        write_d      = we_d;
                        byteenable_d = be_req;
                        writedata_d  = wdata_req;
                        cnt_d        = '0;
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    byteenable_d = 4'b0000;
                    if (sel_data_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = we_q ? 32'h0 : load_ext;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = readdata;
                    end
                end else if (timed_out) begin
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    byteenable_d = 4'b0000;
                    i_ack_d      = ~sel_data_q;
                    i_fault_d    = ~sel_data_q;
                    d_ack_d      = sel_data_q;
                    d_fault_d    = sel_data_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output and context registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values
        if (reset) begin
            address_q    <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            sel_data_q   <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= '0;
            sext_q       <= 1'b0;
            lane_q       <= '0;
            last_data_q  <= 1'b0;
            cnt_q        <= '0;
            i_ack_q      <= 1'b0;
            i_rdata_q    <= '0;
            i_fault_q    <= 1'b0;
            d_ack_q      <= 1'b0;
            d_rdata_q    <= '0;
            d_fault_q    <= 1'b0;
        end else begin
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            sel_data_q   <= sel_data_d;
            we_q         <= we_d;
            size_q       <= size_d;
            sext_q       <= sext_d;
            lane_q       <= lane_d;
            last_data_q  <= last_data_d;
            cnt_q        <= cnt_d;
            i_ack_q      <= i_ack_d;
            i_rdata_q    <= i_rdata_d;
            i_fault_q    <= i_fault_d;
            d_ack_q      <= d_ack_d;
            d_rdata_q    <= d_rdata_d;
            d_fault_q    <= d_fault_d;
        end
    end

    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
    assign i_ack      = i_ack_q;
    assign i_rdata    = i_rdata_q;
    assign i_fault    = i_fault_q;
    assign d_ack      = d_ack_q;
    assign d_rdata    = d_rdata_q;
    assign d_fault    = d_fault_q;

endmodule

// File: tb/tb_mips_avalon_master.sv
// Directed testbench for mips_avalon_master (DATA_PRIORITY=1, TIMEOUT_CYCLES=4).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_mips_avalon_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_fault;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_signed;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_fault;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    int n_cmp = 0;
    int n_err = 0;

    mips_avalon_master #(
        .ADDR_WIDTH    (32),
        .DATA_PRIORITY (1'b1),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_ack      (i_ack),
        .i_rdata    (i_rdata),
        .i_fault    (i_fault),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_size     (d_size),
        .d_signed   (d_signed),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .d_fault    (d_fault),
        .address    (address),
        .read       (read),
        .write      (write),
        .waitrequest(waitrequest),
        .writedata  (writedata),
        .byteenable (byteenable),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req       = 1'b0;
        i_addr      = 32'h0;
        d_req       = 1'b0;
        d_we        = 1'b0;
        d_size      = 2'b00;
        d_signed    = 1'b0;
        d_addr      = 32'h0;
        d_wdata     = 32'h0;
        waitrequest = 1'b0;
        readdata    = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({read, write, i_ack, d_ack, i_fault, d_fault} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: read/write/iack/dack/ifault/dfault=%b expected 000000",
                     {read, write, i_ack, d_ack, i_fault, d_fault});
        end
        n_cmp++;
        if ({address, writedata, byteenable} !== 68'h0) begin
            n_err++;
            $display("FAIL reset_bus: address=%h writedata=%h byteenable=%b expected all 0",
                     address, writedata, byteenable);
        end
        n_cmp++;
        if ({i_rdata, d_rdata} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_rdata: i_rdata=%h d_rdata=%h expected 0", i_rdata, d_rdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        i_req       = 1'b1;
        i_addr      = 32'hBFC0_0000;
        waitrequest = 1'b0;
        readdata    = 32'h2402_0005;
        tick();  // cycle 1
        n_cmp++;
        if ({read, write, address, byteenable, i_ack} !== {1'b1, 1'b0, 32'hBFC0_0000, 4'b1111, 1'b0}) begin
            n_err++;
            $display("FAIL fetch_bus: read=%b write=%b address=%h be=%b i_ack=%b expected 1 0 bfc00000 1111 0",
                     read, write, address, byteenable, i_ack);
        end
        tick();  // cycle 2
        n_cmp++;
        if ({i_ack, i_fault, i_rdata, d_ack, read} !== {1'b1, 1'b0, 32'h2402_0005, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL fetch_ack: i_ack=%b i_fault=%b i_rdata=%h d_ack=%b read=%b expected 1 0 24020005 0 0",
                     i_ack, i_fault, i_rdata, d_ack, read);
        end
        i_req = 1'b0;
        tick();  // cycle 3
        n_cmp++;
        if ({i_ack, read} !== 2'b00) begin
            n_err++;
            $display("FAIL fetch_idle: i_ack=%b read=%b expected 0 0", i_ack, read);
        end
    endtask

    task automatic test_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                             input logic sgn, input logic [31:0] rdata, input int waits,
                             input logic [31:0] exp_addr, input logic [31:0] exp_data);
        d_req       = 1'b1;
        d_we        = 1'b0;
        d_size      = size;
        d_signed    = sgn;
        d_addr      = addr;
        readdata    = rdata;
        waitrequest = (waits != 0);
        for (int k = 1; k <= waits + 1; k++) begin
            tick();
            if (k == waits + 1) waitrequest = 1'b0;
            n_cmp++;
            if ({read, write, address, d_ack} !== {1'b1, 1'b0, exp_addr, 1'b0}) begin
                n_err++;
                $display("FAIL %s_bus_c%0d: read=%b write=%b address=%h d_ack=%b expected 1 0 %h 0",
                         name, k, read, write, address, d_ack, exp_addr);
            end
        end
        tick();
        n_cmp++;
        if ({d_ack, d_fault, d_rdata, read} !== {1'b1, 1'b0, exp_data, 1'b0}) begin
            n_err++;
            $display("FAIL %s_ack: d_ack=%b d_fault=%b d_rdata=%h read=%b expected 1 0 %h 0",
                     name, d_ack, d_fault, d_rdata, read, exp_data);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_store(input string name, input logic [31:0] addr, input logic [1:0] size,
                              input logic [31:0] wdata, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd);
        d_req       = 1'b1;
        d_we        = 1'b1;
        d_size      = size;
        d_signed    = 1'b0;
        d_addr      = addr;
        d_wdata     = wdata;
        readdata    = 32'h5555_AAAA;
        waitrequest = 1'b0;
        tick();
        n_cmp++;
        if ({write, read, address, byteenable, writedata} !== {1'b1, 1'b0, exp_addr, exp_be, exp_wd}) begin
            n_err++;
            $display("FAIL %s_bus: write=%b read=%b address=%h be=%b writedata=%h expected 1 0 %h %b %h",
                     name, write, read, address, byteenable, writedata, exp_addr, exp_be, exp_wd);
        end
        tick();
        n_cmp++;
        if ({d_ack, d_fault, d_rdata, write, byteenable} !== {1'b1, 1'b0, 32'h0, 1'b0, 4'b0000}) begin
            n_err++;
            $display("FAIL %s_ack: d_ack=%b d_fault=%b d_rdata=%h write=%b be=%b expected 1 0 0 0 0000",
                     name, d_ack, d_fault, d_rdata, write, byteenable);
        end
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
    endtask

    task automatic test_fault(input string name, input logic is_data, input logic we,
                              input logic [1:0] size, input logic [31:0] addr);
        readdata    = 32'hFFFF_FFFF;
        waitrequest = 1'b0;
        if (is_data) begin
            d_req  = 1'b1;
            d_we   = we;
            d_size = size;
            d_addr = addr;
        end else begin
            i_req  = 1'b1;
            i_addr = addr;
        end
        tick();  // cycle 1
        n_cmp++;
        if (is_data && ({d_ack, d_fault, d_rdata, i_ack, read, write} !== {1'b1, 1'b1, 32'h0, 3'b000})) begin
            n_err++;
            $display("FAIL %s_ack: d_ack=%b d_fault=%b d_rdata=%h i_ack=%b read=%b write=%b expected 1 1 0 0 0 0",
                     name, d_ack, d_fault, d_rdata, i_ack, read, write);
        end else if (!is_data && ({i_ack, i_fault, i_rdata, d_ack, read, write} !== {1'b1, 1'b1, 32'h0, 3'b000})) begin
            n_err++;
            $display("FAIL %s_ack: i_ack=%b i_fault=%b i_rdata=%h d_ack=%b read=%b write=%b expected 1 1 0 0 0 0",
                     name, i_ack, i_fault, i_rdata, d_ack, read, write);
        end
        d_req = 1'b0;
        i_req = 1'b0;
        d_we  = 1'b0;
        tick();  // cycle 2
        n_cmp++;
        if ({i_ack, d_ack, read, write} !== 4'b0000) begin
            n_err++;
            $display("FAIL %s_after: i_ack=%b d_ack=%b read=%b write=%b expected 0000",
                     name, i_ack, d_ack, read, write);
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        i_req       = 1'b1;
        i_addr      = 32'h0040_0000;
        d_req       = 1'b1;
        d_we        = 1'b0;
        d_size      = 2'b10;
        d_addr      = 32'h0000_1000;
        readdata    = 32'hCAFE_F00D;
        waitrequest = 1'b0;
        for (int r = 0; r < 4; r++) begin
            logic        exp_data;
            logic [31:0] exp_addr;
            exp_data = (r % 2 == 0);
            exp_addr = exp_data ? 32'h0000_1000 : 32'h0040_0000;
            tick();
            n_cmp++;
            if ({read, address} !== {1'b1, exp_addr}) begin
                n_err++;
                $display("FAIL arb_r%0d_bus: read=%b address=%h expected 1 %h", r, read, address, exp_addr);
            end
            tick();
            n_cmp++;
            if ({d_ack, i_ack} !== {exp_data, ~exp_data} ||
                (exp_data ? d_rdata : i_rdata) !== 32'hCAFE_F00D) begin
                n_err++;
                $display("FAIL arb_r%0d_ack: d_ack=%b i_ack=%b d_rdata=%h i_rdata=%h expected d_ack=%b i_ack=%b rdata=cafef00d",
                         r, d_ack, i_ack, d_rdata, i_rdata, exp_data, ~exp_data);
            end
            tick();
            n_cmp++;
            if ({read, d_ack, i_ack} !== 3'b000) begin
                n_err++;
                $display("FAIL arb_r%0d_idle: read=%b d_ack=%b i_ack=%b expected 000", r, read, d_ack, i_ack);
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        d_req       = 1'b1;
        d_we        = 1'b0;
        d_size      = 2'b10;
        d_addr      = 32'h0000_4000;
        readdata    = 32'h1234_5678;
        waitrequest = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++;
            if ({read, address, d_ack} !== {1'b1, 32'h0000_4000, 1'b0}) begin
                n_err++;
                $display("FAIL timeout_stall_c%0d: read=%b address=%h d_ack=%b expected 1 00004000 0",
                         k, read, address, d_ack);
            end
        end
        tick();  // cycle 5
        n_cmp++;
        if ({read, d_ack, d_fault, d_rdata} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL timeout_abort: read=%b d_ack=%b d_fault=%b d_rdata=%h expected 0 1 1 0",
                     read, d_ack, d_fault, d_rdata);
        end
        d_req       = 1'b0;
        waitrequest = 1'b0;
        tick();
        n_cmp++;
        if ({read, d_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL timeout_after: read=%b d_ack=%b expected 00", read, d_ack);
        end
    endtask

    task automatic test_reset_mid_bus();
        i_req       = 1'b1;
        i_addr      = 32'h0040_0000;
        readdata    = 32'h0BAD_F00D;
        waitrequest = 1'b1;
        tick();  // cycle 1: in BUS
        n_cmp++;
        if (read !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_bus: read=%b expected 1", read);
        end
        reset = 1'b1;
        tick();  // cycle 2
        n_cmp++;
        if ({read, i_ack, i_fault} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_mid_drop: read=%b i_ack=%b i_fault=%b expected 000", read, i_ack, i_fault);
        end
        reset       = 1'b0;
        i_req       = 1'b0;
        waitrequest = 1'b0;
        tick();  // cycle 3
        n_cmp++;
        if ({read, i_ack, d_ack} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_mid_noack: read=%b i_ack=%b d_ack=%b expected 000", read, i_ack, d_ack);
        end
        i_req = 1'b1;
        tick();
        n_cmp++;
        if ({read, address} !== {1'b1, 32'h0040_0000}) begin
            n_err++;
            $display("FAIL rst_mid_restart: read=%b address=%h expected 1 00400000", read, address);
        end
        tick();
        n_cmp++;
        if ({i_ack, i_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
            n_err++;
            $display("FAIL rst_mid_ack: i_ack=%b i_rdata=%h expected 1 0badf00d", i_ack, i_rdata);
        end
        i_req = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_load("lb_signed",   32'h0000_1003, 2'b00, 1'b1, 32'h80FF_1234, 3, 32'h0000_1000, 32'hFFFF_FF80);
        test_load("lbu",         32'h0000_1003, 2'b00, 1'b0, 32'h80FF_1234, 3, 32'h0000_1000, 32'h0000_0080);
        test_load("lbu_lane1",   32'h0000_1001, 2'b00, 1'b0, 32'h80FF_1234, 0, 32'h0000_1000, 32'h0000_0012);
        test_load("lh_signed",   32'h0000_1002, 2'b01, 1'b1, 32'h80FF_1234, 0, 32'h0000_1000, 32'hFFFF_80FF);
        test_load("lhu_low",     32'h0000_1000, 2'b01, 1'b0, 32'h80FF_9234, 1, 32'h0000_1000, 32'h0000_9234);
        test_store("sh",         32'h0000_2002, 2'b01, 32'hDEAD_BEEF, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF);
        test_store("sb",         32'h0000_2001, 2'b00, 32'hDEAD_BEEF, 32'h0000_2000, 4'b0010, 32'hEFEF_EFEF);
        test_store("sw",         32'h0000_2004, 2'b10, 32'h1234_5678, 32'h0000_2004, 4'b1111, 32'h1234_5678);
        test_fault("lw_misalign", 1'b1, 1'b0, 2'b10, 32'h0000_3001);
        test_fault("size_rsvd",   1'b1, 1'b1, 2'b11, 32'h0000_3000);
        test_fault("lh_misalign", 1'b1, 1'b0, 2'b01, 32'h0000_3003);
        test_fault("fetch_mis",   1'b0, 1'b0, 2'b10, 32'h0040_0002);
        test_back_to_back();
        test_timeout();
        test_reset_mid_bus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
